// File: rtl/accel_mag_sqrt_requester.sv
// -----------------------------------------------------------------------------
// accel_mag_sqrt_requester
//
// Purpose:
//   Takes one signed 3-axis accelerometer sample and computes ax^2+ay^2+az^2
//   exactly with a bit-serial shift-add multiplier (16 cycles per axis). It
//   then sends the sum to a scalar square-root responder and returns the
//   root as the acceleration magnitude for the fall-detection feature path.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   sample handshake; ax/ay/az are signed axis samples
//   sqrt_start          one-cycle request pulse to the responder
//   sqrt_value          unsigned radicand, stable from start until next accept
//   sqrt_in/sqrt_valid  root and result strobe from the responder
//   sumsq_out           last computed sum of squares
//   mag_out/mag_valid   last magnitude and its one-cycle update strobe
//   timeout_err         one-cycle strobe: responder did not answer in time
//   busy                high whenever the block is not idle
//
// Handshake: a sample is taken in any cycle where in_valid && in_ready.
//   in_ready is high only while idle, so nothing is queued; in_valid while
//   busy is ignored. The responder handshake is start/valid: sqrt_start is a
//   single-cycle pulse and sqrt_valid is honoured only while waiting for it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module accel_mag_sqrt_requester #(
  parameter int SAMPLE_W = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SAMPLE_W-1:0]   ax,
  input  logic [SAMPLE_W-1:0]   ay,
  input  logic [SAMPLE_W-1:0]   az,
  output logic                  sqrt_start,
  output logic [2*SAMPLE_W-1:0] sqrt_value,
  input  logic [SAMPLE_W-1:0]   sqrt_in,
  input  logic                  sqrt_valid,
  output logic [2*SAMPLE_W-1:0] sumsq_out,
  output logic [SAMPLE_W-1:0]   mag_out,
  output logic                  mag_valid,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int ACC_W = 2 * SAMPLE_W;
  localparam int BIT_W = $clog2(SAMPLE_W);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_REQ  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // state_q is kept as a plain named register so checkers can bind to it.
  state_t              state_q;
  logic [SAMPLE_W-1:0] abs_x_q, abs_y_q, abs_z_q;
  logic [ACC_W-1:0]    acc_q;
  logic [1:0]          axis_q;
  logic [BIT_W-1:0]    bit_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                sqrt_start_q;
  logic [ACC_W-1:0]    sqrt_value_q;
  logic [ACC_W-1:0]    sumsq_q;
  logic [SAMPLE_W-1:0] mag_q;
  logic                mag_valid_q;
  logic                timeout_err_q;

  // Two's-complement magnitude as unsigned; the most negative value maps to
  // 2^(SAMPLE_W-1), which still fits the unsigned width.
  function automatic logic [SAMPLE_W-1:0] abs_f(input logic [SAMPLE_W-1:0] v);
    return v[SAMPLE_W-1] ? ((~v) + {{(SAMPLE_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Multiplier datapath: square the current axis one bit per cycle.
  logic [SAMPLE_W-1:0] op;
  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    acc_d;
  logic                last_bit;
  logic                last_axis;

  always_comb begin
    op = abs_x_q;
    case (axis_q)
      2'd1:    op = abs_y_q;
      2'd2:    op = abs_z_q;
      default: op = abs_x_q;
    endcase
    addend    = op[bit_q] ? ({{SAMPLE_W{1'b0}}, op} << bit_q) : '0;
    acc_d     = acc_q + addend;
    last_bit  = (bit_q == BIT_W'(SAMPLE_W - 1));
    last_axis = (axis_q == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      abs_x_q       <= '0;
      abs_y_q       <= '0;
      abs_z_q       <= '0;
      acc_q         <= '0;
      axis_q        <= '0;
      bit_q         <= '0;
      cnt_q         <= '0;
      sqrt_start_q  <= 1'b0;
      sqrt_value_q  <= '0;
      sumsq_q       <= '0;
      mag_q         <= '0;
      mag_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      sqrt_start_q  <= 1'b0;
      mag_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            abs_x_q <= abs_f(ax);
            abs_y_q <= abs_f(ay);
            abs_z_q <= abs_f(az);
            acc_q   <= '0;
            axis_q  <= 2'd0;
            bit_q   <= '0;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          if (last_bit) begin
            bit_q <= '0;
            if (last_axis) begin
              // Load the request registers now so they are visible in the
              // same cycle as the start pulse.
              sqrt_start_q <= 1'b1;
              sqrt_value_q <= acc_d;
              sumsq_q      <= acc_d;
              state_q      <= S_REQ;
            end else begin
              axis_q <= axis_q + 2'd1;
            end
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        S_REQ: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (sqrt_valid) begin
            mag_q       <= sqrt_in;
            mag_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // TIMEOUT wait cycles have passed without an answer.
            timeout_err_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign sqrt_start  = sqrt_start_q;
  assign sqrt_value  = sqrt_value_q;
  assign sumsq_out   = sumsq_q;
  assign mag_out     = mag_q;
  assign mag_valid   = mag_valid_q;
  assign timeout_err = timeout_err_q;

endmodule
